// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the floating-point normalize/round pipeline.
//   fp_class_e    : classification of the incoming adder result
//   rnd_mode_e    : IEEE-754 rounding direction
//   FLAG_*        : bit positions inside the 4-bit flags vector
//   canonical_nan : canonical quiet NaN encoding for a given format
package fp_norm_pkg;

  typedef enum logic [2:0] {
    CLS_NORM    = 3'd0,
    CLS_ZERO    = 3'd1,
    CLS_INF     = 3'd2,
    CLS_QNAN    = 3'd3,
    CLS_INVALID = 3'd4
  } fp_class_e;

  typedef enum logic [1:0] {
    RND_RNE = 2'd0,
    RND_RTZ = 2'd1,
    RND_RUP = 2'd2,
    RND_RDN = 2'd3
  } rnd_mode_e;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  // Sign 0, exponent all ones, mantissa MSB set; returned right-aligned in
  // 64 bits so callers slice off the width they need.
  function automatic logic [63:0] canonical_nan(input int exp_w, input int man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter.
//   data_i  : WIDTH-bit input vector
//   count_o : number of zeros above the most significant set bit;
//             WIDTH when data_i is all zero
module fp_lzc #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0]           data_i,
  output logic [$clog2(WIDTH+1)-1:0] count_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage normalize / round / pack pipeline for a floating-point adder.
//   Stage 1: carry right-shift or LZC-driven left shift, special-class handling.
//   Stage 2: rounding, exponent adjust, overflow/underflow, packing.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : input handshake
//   in_sign/in_exp/in_man      : pre-normalized result ({carry, hidden, frac})
//   in_grs                     : {guard, round, sticky}
//   in_class, rnd_mode         : operand class and rounding mode of the beat
//   out_valid/out_ready        : output handshake
//   out_result, out_flags      : packed result, {invalid, overflow, underflow, inexact}
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_man,
  input  logic [2:0]             in_grs,
  input  fp_class_e              in_class,
  input  rnd_mode_e              rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [3:0]             out_flags
);

  localparam int SIG_W = MAN_W + 1;
  localparam int RES_W = 1 + EXP_W + MAN_W;
  localparam int LZC_W = $clog2(SIG_W + 1);
  localparam logic [63:0]      QNAN_FULL = canonical_nan(EXP_W, MAN_W);
  localparam logic [RES_W-1:0] QNAN      = QNAN_FULL[RES_W-1:0];
  localparam logic [EXP_W:0]   EXP_MAX   = {1'b0, {EXP_W{1'b1}}};

  // Exponent carries one extra bit so a carry into all-ones is visible.
  typedef struct packed {
    logic             sign;
    logic [EXP_W:0]   exp;
    logic [SIG_W-1:0] sig;
    logic             g;
    logic             r;
    logic             s;
    fp_class_e        cls;
    rnd_mode_e        rnd;
  } s1_t;

  s1_t              s1_d, s1_q;
  logic             s1_valid_q, s2_valid_q;
  logic             s2_load, s1_advance;
  logic [LZC_W-1:0] lzc;
  logic [EXP_W:0]   shift_cap, shift_amt;
  logic [SIG_W+1:0] shifted;
  logic             inc, inexact, ovf;
  logic [SIG_W:0]   sum;
  logic [EXP_W:0]   exp_rnd;
  logic [RES_W-1:0] res_d, res_q;
  logic [3:0]       flags_d, flags_q;

  // Handshake: each stage loads when empty or when its consumer takes it.
  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_load;
  assign in_ready   = !s1_valid_q || s1_advance;

  fp_lzc #(.WIDTH(SIG_W)) u_lzc (
    .data_i  (in_man[MAN_W:0]),
    .count_o (lzc)
  );

  // Stage 1: normalize
  always_comb begin
    // Left shift may not drive the exponent below 1; beyond that the value
    // stays subnormal and the hidden bit remains clear.
    shift_cap = (in_exp == '0) ? '0 : {1'b0, in_exp} - (EXP_W+1)'(1);
    shift_amt = ((EXP_W+1)'(lzc) > shift_cap) ? shift_cap : (EXP_W+1)'(lzc);
    shifted   = {in_man[MAN_W:0], in_grs[2], in_grs[1]} << shift_amt;

    s1_d      = '0;
    s1_d.sign = in_sign;
    s1_d.cls  = in_class;
    s1_d.rnd  = rnd_mode;
    if (in_class == CLS_NORM && in_man == '0) begin
      // Exact cancellation: signed zero, negative when rounding down.
      s1_d.cls  = CLS_ZERO;
      s1_d.sign = (rnd_mode == RND_RDN) ? 1'b1 : in_sign;
    end else if (in_man[MAN_W+1]) begin
      s1_d.exp = {1'b0, in_exp} + (EXP_W+1)'(1);
      s1_d.sig = in_man[MAN_W+1:1];
      s1_d.g   = in_man[0];
      s1_d.r   = in_grs[2];
      s1_d.s   = in_grs[1] | in_grs[0];
    end else begin
      s1_d.sig = shifted[SIG_W+1:2];
      s1_d.g   = shifted[1];
      s1_d.r   = shifted[0];
      s1_d.s   = in_grs[0];
      s1_d.exp = shifted[SIG_W+1] ? ({1'b0, in_exp} - shift_amt) : '0;
    end
  end

  // Stage 2: round and pack
  always_comb begin
    inexact = s1_q.g | s1_q.r | s1_q.s;
    inc     = 1'b0;
    case (s1_q.rnd)
      RND_RNE: inc = s1_q.g & (s1_q.r | s1_q.s | s1_q.sig[0]);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = inexact & ~s1_q.sign;
      RND_RDN: inc = inexact & s1_q.sign;
      default: inc = 1'b0;
    endcase

    // A carry out of the significand leaves the fraction bits all zero.
    sum     = {1'b0, s1_q.sig} + (SIG_W+1)'(inc);
    exp_rnd = s1_q.exp;
    if (sum[SIG_W]) begin
      exp_rnd = s1_q.exp + (EXP_W+1)'(1);
    end else if (s1_q.exp == '0 && sum[SIG_W-1]) begin
      // Subnormal rounded up into the smallest normal.
      exp_rnd = (EXP_W+1)'(1);
    end
    ovf = (exp_rnd >= EXP_MAX);

    res_d   = {s1_q.sign, exp_rnd[EXP_W-1:0], sum[MAN_W-1:0]};
    flags_d = '0;
    flags_d[FLAG_INEXACT]   = inexact;
    flags_d[FLAG_UNDERFLOW] = inexact && (exp_rnd == '0);

    if (ovf) begin
      flags_d[FLAG_OVERFLOW] = 1'b1;
      flags_d[FLAG_INEXACT]  = 1'b1;
      // Modes rounding toward zero for this sign saturate to max finite.
      if (s1_q.rnd == RND_RTZ || (s1_q.rnd == RND_RUP && s1_q.sign) ||
          (s1_q.rnd == RND_RDN && !s1_q.sign))
        res_d = {s1_q.sign, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
      else
        res_d = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    case (s1_q.cls)
      CLS_ZERO: begin
        res_d   = {s1_q.sign, {(RES_W-1){1'b0}}};
        flags_d = '0;
      end
      CLS_INF: begin
        res_d   = {s1_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        flags_d = '0;
      end
      CLS_QNAN: begin
        res_d   = QNAN;
        flags_d = '0;
      end
      CLS_INVALID: begin
        res_d   = QNAN;
        flags_d = '0;
        flags_d[FLAG_INVALID] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q   <= res_d;
          flags_q <= flags_d;
        end
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = res_q;
  assign out_flags  = flags_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Testbench for fp_normalize_pipe (EXP_W=8, MAN_W=23): table of directed
// vectors with hand-computed results, plus backpressure and reset sequences.
module tb_fp_normalize_pipe;
  import fp_norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_man = '0;
  logic [2:0]  in_grs = '0;
  fp_class_e   in_class = CLS_NORM;
  rnd_mode_e   rnd_mode = RND_RNE;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_normalize_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_man     (in_man),
    .in_grs     (in_grs),
    .in_class   (in_class),
    .rnd_mode   (rnd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;
    logic [2:0]  grs;
    fp_class_e   cls;
    rnd_mode_e   rnd;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_man   = v.man;
    in_grs   = v.grs;
    in_class = v.cls;
    rnd_mode = v.rnd;
  endtask

  // Single beat: accept, expect it on the second negedge after driving.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc;
    @(negedge clk);
    out_ready = 1'b1;
    check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_latency", idx), 32'(cyc), 32'd2);
    check($sformatf("v%0d_result", idx), out_result, v.res);
    check($sformatf("v%0d_flags", idx), 32'(out_flags), 32'(v.flags));
    $display("vec %0d: exp=%h man=%h grs=%b cls=%0d rnd=%0d -> result=%h flags=%b lat=%0d",
             idx, v.exp, v.man, v.grs, v.cls, v.rnd, out_result, out_flags, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t bp[3];
    int   sent;
    int   got;

    //          sign  exp    man            grs     class        rnd      result        flags
    vecs[0]  = '{1'b0, 8'h7F, 25'h1000000, 3'b000, CLS_NORM,    RND_RNE, 32'h40000000, 4'b0000};
    vecs[1]  = '{1'b0, 8'h80, 25'h0400000, 3'b000, CLS_NORM,    RND_RNE, 32'h3F800000, 4'b0000};
    vecs[2]  = '{1'b0, 8'h7F, 25'h0800001, 3'b100, CLS_NORM,    RND_RNE, 32'h3F800002, 4'b0001};
    vecs[3]  = '{1'b0, 8'h7F, 25'h0800001, 3'b100, CLS_NORM,    RND_RTZ, 32'h3F800001, 4'b0001};
    vecs[4]  = '{1'b0, 8'hFE, 25'h1800000, 3'b000, CLS_NORM,    RND_RNE, 32'h7F800000, 4'b0101};
    vecs[5]  = '{1'b0, 8'hFE, 25'h1800000, 3'b000, CLS_NORM,    RND_RTZ, 32'h7F7FFFFF, 4'b0101};
    vecs[6]  = '{1'b1, 8'hFE, 25'h1800000, 3'b000, CLS_NORM,    RND_RUP, 32'hFF7FFFFF, 4'b0101};
    vecs[7]  = '{1'b1, 8'hFE, 25'h1800000, 3'b000, CLS_NORM,    RND_RDN, 32'hFF800000, 4'b0101};
    vecs[8]  = '{1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, CLS_NORM,    RND_RNE, 32'h40000000, 4'b0001};
    vecs[9]  = '{1'b0, 8'h7F, 25'h1000001, 3'b000, CLS_NORM,    RND_RNE, 32'h40000000, 4'b0001};
    vecs[10] = '{1'b0, 8'h7F, 25'h1800001, 3'b000, CLS_NORM,    RND_RNE, 32'h40400000, 4'b0001};
    vecs[11] = '{1'b0, 8'h03, 25'h0000100, 3'b000, CLS_NORM,    RND_RNE, 32'h00000400, 4'b0000};
    vecs[12] = '{1'b0, 8'h01, 25'h0400000, 3'b001, CLS_NORM,    RND_RNE, 32'h00400000, 4'b0011};
    vecs[13] = '{1'b0, 8'h7F, 25'h0800000, 3'b001, CLS_NORM,    RND_RUP, 32'h3F800001, 4'b0001};
    vecs[14] = '{1'b0, 8'h7F, 25'h0800000, 3'b001, CLS_NORM,    RND_RDN, 32'h3F800000, 4'b0001};
    vecs[15] = '{1'b1, 8'h7F, 25'h0800000, 3'b001, CLS_NORM,    RND_RDN, 32'hBF800001, 4'b0001};
    vecs[16] = '{1'b0, 8'h80, 25'h0000000, 3'b000, CLS_NORM,    RND_RNE, 32'h00000000, 4'b0000};
    vecs[17] = '{1'b0, 8'h80, 25'h0000000, 3'b000, CLS_NORM,    RND_RDN, 32'h80000000, 4'b0000};
    vecs[18] = '{1'b1, 8'h55, 25'h0123456, 3'b000, CLS_ZERO,    RND_RNE, 32'h80000000, 4'b0000};
    vecs[19] = '{1'b1, 8'h00, 25'h0000000, 3'b000, CLS_INF,     RND_RNE, 32'hFF800000, 4'b0000};
    vecs[20] = '{1'b1, 8'h12, 25'h0000123, 3'b111, CLS_QNAN,    RND_RNE, 32'h7FC00000, 4'b0000};
    vecs[21] = '{1'b0, 8'h00, 25'h0000000, 3'b000, CLS_INVALID, RND_RNE, 32'h7FC00000, 4'b1000};

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

    // Backpressure: 3 beats back-to-back, out_ready low for the first 4 cycles.
    bp[0] = vecs[0];
    bp[1] = vecs[1];
    bp[2] = vecs[2];
    sent = 0;
    got  = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk);
      out_ready = (k >= 4);
      if (sent < 3) begin
        drive(bp[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
      if (out_valid && !out_ready) begin
        check($sformatf("bp_hold_result_k%0d", k), out_result, bp[got].res);
        check($sformatf("bp_hold_flags_k%0d", k), 32'(out_flags), 32'(bp[got].flags));
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d_result", got), out_result, bp[got].res);
        check($sformatf("bp_out%0d_flags", got), 32'(out_flags), 32'(bp[got].flags));
        $display("bp beat %0d: result=%h flags=%b cycle=%0d", got, out_result, out_flags, k);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check("bp_delivered", 32'(got), 32'd3);

    // Reset with two beats in flight.
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[4]);
    in_valid = 1'b1;
    @(negedge clk);
    drive(vecs[8]);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_out_valid_before_rst", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_result", out_result, 32'd0);
    check("mid_rst_out_flags", 32'(out_flags), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    $display("reset mid-flight: out_valid=%b out_result=%h", out_valid, out_result);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_idle_k%0d", k), 32'(out_valid), 32'd0);
    end
    run_vec(100, vecs[10]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pipe.md
FP_NORMALIZE_PIPE -- requirements
Module: fp_normalize_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width (hidden bit excluded).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block accepts beat when in_valid && in_ready.
REQ-007 in_sign  input  1  sign of aligned result.
REQ-008 in_exp  input  EXP_W  pre-normalization exponent.
REQ-009 in_man  input  MAN_W+2  {carry, hidden, mantissa} of adder result.
REQ-010 in_grs  input  3  {guard, round, sticky}.
REQ-011 in_class  input  3  fp_class_e: NORM, ZERO, INF, QNAN, INVALID.
REQ-012 rnd_mode  input  2  rnd_mode_e: RNE, RTZ, RUP, RDN; sampled with the beat.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  1+EXP_W+MAN_W  {sign, exponent, mantissa}.
REQ-016 out_flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-017 SHALL be a 2-stage pipeline: S1 = carry/LZC/shift/classify, S2 = round/exponent adjust/pack; latency 2 cycles, throughput 1 beat/cycle with out_ready high.
REQ-018 Each stage register SHALL load when empty or when its consumer takes it; in_ready = !s1_valid || s1_advance (combinational from out_ready).
REQ-019 While out_valid && !out_ready, out_result/out_flags SHALL hold stable; no beat dropped, duplicated or reordered.
REQ-020 Carry set: mantissa shifted right 1, exponent +1, new guard = man[0], round = old guard, sticky = old round | old sticky.
REQ-021 No carry: left shift by leading-zero count of {hidden, mantissa}, capped at in_exp-1; if capped, exponent field = 0 (subnormal).
REQ-022 Mantissa all zero with class NORM SHALL yield signed zero (sign = in_sign, RDN forces sign 1 on exact cancellation).
REQ-023 Rounding: RNE increments on G && (R|S|lsb); RTZ never; RUP on (G|R|S) && !sign; RDN on (G|R|S) && sign.
REQ-024 Rounding carry out of mantissa SHALL increment exponent and clear mantissa.
REQ-025 Exponent reaching all-ones: overflow+inexact set; result = inf for RNE, max finite for RTZ, inf/max-finite by sign for RUP/RDN.
REQ-026 inexact = G|R|S after shift; underflow = inexact && result exponent field 0.
REQ-027 ZERO class: signed zero, flags 0. INF: signed inf, flags 0. QNAN: canonical qNaN (sign 0, exp all ones, mantissa MSB 1). INVALID: canonical qNaN, invalid flag set.

Reset
REQ-028 rst_n low SHALL asynchronously clear both stage valid bits; out_valid=0, out_result=0, out_flags=0, in_ready=1 while in reset.
REQ-029 In-flight beats at reset SHALL be discarded; first beat after release emerges 2 cycles after acceptance.

Structure
REQ-030 Package fp_norm_pkg SHALL hold fp_class_e, rnd_mode_e, flag bit index constants and canonical-NaN function of EXP_W/MAN_W.
REQ-031 Leading-zero count SHALL be sub-module fp_lzc, parametrised by width, output clog2(width+1) bits, all-zero input returns width.

Verification (EXP_W=8, MAN_W=23)
REQ-032 1.0+1.0: in_exp=0x7F, in_man={2'b10,23'b0}, grs=0, RNE -> out_result 0x40000000, flags 0, 2 cycles later.
REQ-033 Cancellation: in_exp=0x80, in_man=25'h0400000, grs=0 -> 0x3F800000, flags 0.
REQ-034 Tie: in_exp=0x7F, in_man=25'h0800001, grs=3'b100 -> RNE 0x3F800002 inexact; RTZ 0x3F800001 inexact.
REQ-035 Overflow: in_exp=0xFE, in_man={2'b11,23'b0} -> RNE 0x7F800000 flags overflow|inexact; RTZ 0x7F7FFFFF.
REQ-036 Backpressure: 3 back-to-back beats, out_ready low 4 cycles -> in_ready falls after 2 held, outputs stable, all 3 delivered in order.
REQ-037 Reset mid-operation: rst_n low with 2 beats in flight -> out_valid 0 immediately, no stale beat after release.
